// File: rtl/morra_match_driver.sv
// Player-side match controller for MorraCinese: opens each game with START/cfg_len, issues LFSR moves, tallies GAME results.
// Optional MORRA_DRV_INVALID_EN: drive raw LFSR 00 moves (invalid) instead of remapping them to rock.
module morra_match_driver #(
    parameter int          NUM_GAMES = 3,
    parameter int          MAX_MOVES = 63,
    parameter logic [7:0]  SEED1     = 8'hA5,
    parameter logic [7:0]  SEED2     = 8'h3C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [3:0] cfg_len,
    output logic [1:0] P1,
    output logic [1:0] P2,
    output logic       START,
    input  logic [1:0] ROUND,
    input  logic [1:0] GAME,
    output logic       busy,
    output logic       done,
    output logic       abort,
    output logic [7:0] p1_games,
    output logic [7:0] p2_games,
    output logic [7:0] tie_games,
    output logic [7:0] moves
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_MOVE  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] NUM_GAMES_B = 8'(NUM_GAMES);
    localparam logic [7:0] MAX_MOVES_B = 8'(MAX_MOVES);

    logic [2:0] state_reg;
    logic [3:0] cfg_reg;
    logic [7:0] game_cnt_reg;
    logic [7:0] lfsr1_reg, lfsr2_reg;
    logic [1:0] p1_reg, p2_reg;
    logic       start_reg, busy_reg, done_reg, abort_reg;
    logic [7:0] p1_games_reg, p2_games_reg, tie_games_reg, moves_reg;

    // ROUND carries no information the tallies need; GAME alone decides a game.
    logic unused_round;
    assign unused_round = ^ROUND;

    function automatic logic [1:0] drive_move(input logic [1:0] raw);
`ifdef MORRA_DRV_INVALID_EN
        return raw;
`else
        return (raw == 2'b00) ? 2'b01 : raw;
`endif
    endfunction

    // Fibonacci taps 8,6,5,4 (bits 7,5,4,3), feedback shifted into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cfg_reg       <= 4'd0;
            game_cnt_reg  <= 8'd0;
            lfsr1_reg     <= SEED1;
            lfsr2_reg     <= SEED2;
            p1_reg        <= 2'b00;
            p2_reg        <= 2'b00;
            start_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            abort_reg     <= 1'b0;
            p1_games_reg  <= 8'd0;
            p2_games_reg  <= 8'd0;
            tie_games_reg <= 8'd0;
            moves_reg     <= 8'd0;
        end else begin
            // Outputs are registered for the state being entered; these are the idle values.
            start_reg <= 1'b0;
            done_reg  <= 1'b0;
            p1_reg    <= 2'b00;
            p2_reg    <= 2'b00;
            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        cfg_reg       <= cfg_len;
                        p1_games_reg  <= 8'd0;
                        p2_games_reg  <= 8'd0;
                        tie_games_reg <= 8'd0;
                        abort_reg     <= 1'b0;
                        game_cnt_reg  <= 8'd0;
                        busy_reg      <= 1'b1;
                        start_reg     <= 1'b1;
                        p1_reg        <= cfg_len[3:2];
                        p2_reg        <= cfg_len[1:0];
                        state_reg     <= S_START;
                    end
                end
                S_START: begin
                    moves_reg <= 8'd0;
                    p1_reg    <= drive_move(lfsr1_reg[1:0]);
                    p2_reg    <= drive_move(lfsr2_reg[1:0]);
                    state_reg <= S_MOVE;
                end
                S_MOVE: begin
                    lfsr1_reg <= lfsr_next(lfsr1_reg);
                    lfsr2_reg <= lfsr_next(lfsr2_reg);
                    moves_reg <= sat_inc(moves_reg);
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (GAME != 2'b00) begin
                        case (GAME)
                            2'b01:   p1_games_reg  <= sat_inc(p1_games_reg);
                            2'b10:   p2_games_reg  <= sat_inc(p2_games_reg);
                            default: tie_games_reg <= sat_inc(tie_games_reg);
                        endcase
                        game_cnt_reg <= game_cnt_reg + 8'd1;
                        if (game_cnt_reg + 8'd1 == NUM_GAMES_B) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_DONE;
                        end else begin
                            start_reg <= 1'b1;
                            p1_reg    <= cfg_reg[3:2];
                            p2_reg    <= cfg_reg[1:0];
                            state_reg <= S_START;
                        end
                    end else if (moves_reg == MAX_MOVES_B) begin
                        abort_reg <= 1'b1;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        p1_reg    <= drive_move(lfsr1_reg[1:0]);
                        p2_reg    <= drive_move(lfsr2_reg[1:0]);
                        state_reg <= S_MOVE;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign P1        = p1_reg;
    assign P2        = p2_reg;
    assign START     = start_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign abort     = abort_reg;
    assign p1_games  = p1_games_reg;
    assign p2_games  = p2_games_reg;
    assign tie_games = tie_games_reg;
    assign moves     = moves_reg;

endmodule

// File: tb/tb_morra_match_driver.sv
// Bench for morra_match_driver: a scripted MorraCinese responder, LFSR move model and match-outcome model.
module tb_morra_match_driver;

    localparam int         NG = 3;
    localparam int         MM = 5;
    localparam logic [7:0] S1 = 8'hA5;
    localparam logic [7:0] S2 = 8'h3C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go  = 1'b0;
    logic [3:0] cfg_len = 4'd0;
    logic [1:0] P1, P2;
    logic [1:0] ROUND = 2'b00;
    logic [1:0] GAME  = 2'b00;
    logic       START, busy, done, abort;
    logic [7:0] p1_games, p2_games, tie_games, moves;

    always #5 clk = ~clk;

    morra_match_driver #(.NUM_GAMES(NG), .MAX_MOVES(MM), .SEED1(S1), .SEED2(S2)) dut (
        .clk(clk), .rst(rst), .go(go), .cfg_len(cfg_len),
        .P1(P1), .P2(P2), .START(START), .ROUND(ROUND), .GAME(GAME),
        .busy(busy), .done(done), .abort(abort),
        .p1_games(p1_games), .p2_games(p2_games), .tie_games(tie_games), .moves(moves)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Responder script: game g ends with result res_s[g] once moves reaches tgt_s[g].
    int         tgt_s[3];
    logic [1:0] res_s[3];
    int         gidx = -1;

    logic [7:0] m1 = S1;
    logic [7:0] m2 = S2;
    bit         exp_move = 1'b0;
    int         nmoves = 0;
    int         nzero  = 0;

    function automatic logic [7:0] step(input logic [7:0] x);
        int ones;
        logic [7:0] y;
        ones = $countones(x & 8'hB8);
        y = x << 1;
        y[0] = ones[0];
        return y;
    endfunction

    function automatic logic [1:0] expect_drive(input logic [7:0] x);
        logic [1:0] r;
        r = x[1:0];
`ifndef MORRA_DRV_INVALID_EN
        if (r == 2'b00) r = 2'b01;
`endif
        return r;
    endfunction

    // Move monitor and DUT-side responder; a game is START, then alternating MOVE/WAIT.
    always @(negedge clk) begin
        ROUND = 2'($urandom_range(0, 3));
        if (rst) begin
            m1 = S1;
            m2 = S2;
            exp_move = 1'b0;
            GAME = 2'b00;
        end else begin
            if (START) begin
                exp_move = 1'b1;
                gidx++;
            end else if (busy) begin
                if (exp_move) begin
                    check("move_p1", P1, expect_drive(m1));
                    check("move_p2", P2, expect_drive(m2));
                    if (P1 == 2'b00 || P2 == 2'b00) nzero++;
                    nmoves++;
                    m1 = step(m1);
                    m2 = step(m2);
                    exp_move = 1'b0;
                end else begin
                    check("wait_drives_00", {P1, P2}, 0);
                    exp_move = 1'b1;
                end
            end
            if (busy && !START && gidx >= 0 && gidx < NG && int'(moves) == tgt_s[gidx])
                GAME = res_s[gidx];
            else
                GAME = 2'b00;
        end
    end

    // Starts at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic run_match(input logic [3:0] cfg, input logic [2:0][7:0] tgt,
                             input logic [2:0][1:0] res, input int ep1, input int ep2,
                             input int etie, input logic eab, input int ecyc);
        int  k;
        bit  seen;
        for (int i = 0; i < 3; i++) begin
            tgt_s[i] = int'(tgt[i]);
            res_s[i] = res[i];
        end
        gidx = -1;
        cfg_len = cfg;
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 400) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check("start_first", START, 1);
                check("busy_first", busy, 1);
                check("abort_cleared", abort, 0);
            end
            if (START) begin
                check("start_p1_cfg", P1, cfg[3:2]);
                check("start_p2_cfg", P2, cfg[1:0]);
            end
            if (k == 2) begin
                go = 1'b1;
                cfg_len = ~cfg;
            end
            if (k == 3) go = 1'b0;
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        check("done_cycle", k, ecyc);
        check("busy_at_done", busy, 0);
        check("p1_games", p1_games, ep1);
        check("p2_games", p2_games, ep2);
        check("tie_games", tie_games, etie);
        check("abort", abort, eab);
        $display("match cfg=%b tgt=%0d/%0d/%0d res=%b/%b/%b -> p1=%0d p2=%0d tie=%0d abort=%0d cycles=%0d",
                 cfg, tgt[0], tgt[1], tgt[2], res[0], res[1], res[2],
                 p1_games, p2_games, tie_games, abort, k);
    endtask

    typedef struct packed {
        logic [3:0]      cfg;
        logic [2:0][7:0] tgt;
        logic [2:0][1:0] res;
        logic [7:0]      ep1;
        logic [7:0]      ep2;
        logic [7:0]      etie;
        logic            eab;
        logic [7:0]      ecyc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int         p1e, p2e, tie_e, cyc;
        logic       ab;
        logic [2:0][7:0] tg;
        logic [2:0][1:0] rs;

        // Fields {game2, game1, game0}.
        vecs[0] = '{4'b0110, {8'd1, 8'd1, 8'd1}, {2'b01, 2'b01, 2'b01}, 8'd3, 8'd0, 8'd0, 1'b0, 8'd10};
        vecs[1] = '{4'b1011, {8'd3, 8'd1, 8'd2}, {2'b01, 2'b11, 2'b10}, 8'd1, 8'd1, 8'd1, 1'b0, 8'd16};
        vecs[2] = '{4'b0001, {8'd5, 8'd5, 8'd5}, {2'b00, 2'b00, 2'b00}, 8'd0, 8'd0, 8'd0, 1'b1, 8'd12};
        vecs[3] = '{4'b1111, {8'd5, 8'd5, 8'd5}, {2'b10, 2'b11, 2'b11}, 8'd0, 8'd1, 8'd2, 1'b0, 8'd34};
        vecs[4] = '{4'b0100, {8'd1, 8'd6, 8'd1}, {2'b01, 2'b10, 2'b01}, 8'd1, 8'd0, 8'd0, 1'b1, 8'd15};

        repeat (2) @(negedge clk);
        check("rst_p1", P1, 0);
        check("rst_p2", P2, 0);
        check("rst_start", START, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_abort", abort, 0);
        check("rst_tallies", {p1_games, p2_games, tie_games}, 0);
        check("rst_moves", moves, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_match(vecs[i].cfg, vecs[i].tgt, vecs[i].res, int'(vecs[i].ep1), int'(vecs[i].ep2),
                      int'(vecs[i].etie), vecs[i].eab, int'(vecs[i].ecyc));
            // go coincident with done must be ignored; the next idle cycle accepts one.
            go = 1'b1;
            cfg_len = 4'($urandom_range(0, 15));
            @(negedge clk);
            check("go_at_done_ignored", {busy, START}, 0);
            check("done_one_cycle", done, 0);
        end

        // Reset during WAIT of game 2.
        tgt_s = '{1, 3, 3};
        res_s = '{2'b01, 2'b01, 2'b01};
        gidx = -1;
        cfg_len = 4'b0110;
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_p1_games", p1_games, 1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_start", START, 0);
        check("midrst_tallies", {p1_games, p2_games, tie_games}, 0);
        check("midrst_moves", moves, 0);
        @(negedge clk);
        check("midrst_no_done", done, 0);
        $display("mid-game reset -> busy=%0d p1=%0d moves=%0d", busy, p1_games, moves);
        run_match(vecs[1].cfg, vecs[1].tgt, vecs[1].res, int'(vecs[1].ep1), int'(vecs[1].ep2),
                  int'(vecs[1].etie), vecs[1].eab, int'(vecs[1].ecyc));
        @(negedge clk);

        // Random matches against the outcome model.
        for (int r = 0; r < 80; r++) begin
            for (int g = 0; g < 3; g++) begin
                tg[g] = 8'($urandom_range(1, 6));
                rs[g] = 2'($urandom_range(0, 3));
            end
            p1e = 0; p2e = 0; tie_e = 0; cyc = 1; ab = 1'b0;
            for (int g = 0; g < NG; g++) begin
                if (!ab) begin
                    if (int'(tg[g]) <= MM && rs[g] != 2'b00) begin
                        cyc += 1 + 2 * int'(tg[g]);
                        if (rs[g] == 2'b01) p1e++;
                        else if (rs[g] == 2'b10) p2e++;
                        else tie_e++;
                    end else begin
                        cyc += 1 + 2 * MM;
                        ab = 1'b1;
                    end
                end
            end
            run_match(4'($urandom_range(0, 15)), tg, rs, p1e, p2e, tie_e, ab, cyc);
            @(negedge clk);
        end

        check("enough_moves", nmoves >= 256, 1);
`ifdef MORRA_DRV_INVALID_EN
        check("zero_move_seen", nzero > 0, 1);
`else
        check("no_zero_move", nzero, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
